// File: rtl/cpu_bus_ctrl.sv
// Fractional-rate CPU clock-enable with a memory handshake.
// Ticks that arrive while an access is stalled are banked as debt and replayed back-to-back.
module cpu_bus_ctrl #(
    parameter int ACC_W  = 16,
    parameter int INC    = 1173,
    parameter int DEBT_W = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [15:0]       cpu_addr,
    input  logic [15:0]       cpu_ea,
    input  logic              cpu_wreq,
    input  logic [DATA_W-1:0] cpu_dout,
    output logic [DATA_W-1:0] cpu_din,
    output logic              cpu_ce,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DEBT_W-1:0] debt,
    output logic              overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [DEBT_W-1:0] DEBT_MAX  = {DEBT_W{1'b1}};
    localparam logic [DEBT_W-1:0] DEBT_ZERO = {DEBT_W{1'b0}};
    localparam logic [DEBT_W-1:0] DEBT_ONE  = DEBT_W'(1);
    localparam logic [ACC_W:0]    INC_EXT   = (ACC_W+1)'(INC);

    state_t             state_r;
    logic [ACC_W-1:0]   acc_r;
    logic               tick_r;
    logic [ACC_W:0]     acc_sum_s;
    logic               launch_s;
    logic [DEBT_W-1:0]  debt_next_s;
    logic               ovr_set_s;

    assign acc_sum_s = {1'b0, acc_r} + INC_EXT;

    // Launch decision: a new CPU cycle starts only from IDLE with banked debt.
    always_comb begin
        launch_s = 1'b0;
        if ((state_r == S_IDLE) && (debt != DEBT_ZERO) && !cpu_ce) begin
            launch_s = 1'b1;
        end else begin
            launch_s = 1'b0;
        end
    end

    // Debt update: tick and launch in the same cycle cancel; a tick at saturation is dropped.
    always_comb begin
        debt_next_s = debt;
        ovr_set_s   = 1'b0;
        if (tick_r && !launch_s) begin
            if (debt == DEBT_MAX) begin
                ovr_set_s = 1'b1;
            end else begin
                debt_next_s = debt + DEBT_ONE;
            end
        end else if (!tick_r && launch_s) begin
            debt_next_s = debt - DEBT_ONE;
        end else begin
            debt_next_s = debt;
        end
    end

    // Phase accumulator; the carry is registered as the tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r  <= {ACC_W{1'b0}};
            tick_r <= 1'b0;
        end else if (enable) begin
            acc_r  <= acc_sum_s[ACC_W-1:0];
            tick_r <= acc_sum_s[ACC_W];
        end else begin
            acc_r  <= acc_r;
            tick_r <= 1'b0;
        end
    end

    // Debt counter and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            debt    <= DEBT_ZERO;
            overrun <= 1'b0;
        end else begin
            debt    <= debt_next_s;
            overrun <= overrun | ovr_set_s;
        end
    end

    // Access FSM with registered memory-side and CPU-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            cpu_ce    <= 1'b0;
            cpu_din   <= {DATA_W{1'b0}};
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    cpu_ce <= 1'b0;
                    if (launch_s) begin
                        mem_we    <= cpu_wreq;
                        mem_addr  <= cpu_wreq ? cpu_ea[ADDR_W-1:0] : cpu_addr[ADDR_W-1:0];
                        mem_wdata <= cpu_dout;
                        mem_req   <= 1'b1;
                        state_r   <= S_WAIT;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            cpu_din <= mem_rdata;
                        end else begin
                            cpu_din <= cpu_din;
                        end
                        cpu_ce  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_DONE: begin
                    cpu_ce  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    cpu_ce  <= 1'b0;
                    mem_req <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Randomized scoreboard bench for cpu_bus_ctrl (INC=16384: one tick every 4 enabled clocks).
module tb_cpu_bus_ctrl;
    localparam int ACC_W = 16, INC = 16384, DEBT_W = 3, ADDR_W = 16, DATA_W = 8;
    localparam int DMAX = 7;

    logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
    logic [15:0] cpu_addr = 16'h0, cpu_ea = 16'h0;
    logic cpu_wreq = 1'b0;
    logic [7:0] cpu_dout = 8'h0, cpu_din, mem_wdata, mem_rdata = 8'h0;
    logic cpu_ce, mem_req, mem_we, mem_ack = 1'b0, overrun;
    logic [15:0] mem_addr;
    logic [2:0] debt;

    cpu_bus_ctrl #(.ACC_W(ACC_W), .INC(INC), .DEBT_W(DEBT_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .cpu_addr(cpu_addr), .cpu_ea(cpu_ea),
        .cpu_wreq(cpu_wreq), .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_ce(cpu_ce),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .debt(debt), .overrun(overrun));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Stimulus knobs (written by the main sequence only)
    bit rand_in = 1'b1, use_fixed = 1'b0, ack_hold = 1'b0, force_ack = 1'b0, spurious = 1'b0;
    int ack_delay = 0;
    logic [15:0] fix_addr = 16'h0, fix_ea = 16'h0;
    logic fix_wreq = 1'b0;
    logic [7:0] fix_dout = 8'h0, rdata_fixed = 8'h0;

    // CPU-side driver
    always @(negedge clk) begin
        if (rand_in) begin
            cpu_addr = 16'($urandom); cpu_ea = 16'($urandom);
            cpu_wreq = 1'($urandom);  cpu_dout = 8'($urandom);
        end else begin
            cpu_addr = fix_addr; cpu_ea = fix_ea; cpu_wreq = fix_wreq; cpu_dout = fix_dout;
        end
    end

    // Memory responder
    int wcnt = 0;
    always @(negedge clk) begin
        mem_ack = 1'b0;
        mem_rdata = use_fixed ? rdata_fixed : 8'($urandom);
        if (force_ack) mem_ack = 1'b1;
        else if (mem_req) begin
            if (!ack_hold) begin
                if (wcnt >= ack_delay) begin mem_ack = 1'b1; wcnt = 0; end
                else wcnt++;
            end
        end else begin
            wcnt = 0;
            if (spurious && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
        end
    end

    // Reference model + scoreboard
    typedef struct packed { logic we; logic [15:0] addr; logic [7:0] wdata; } req_t;
    req_t req_q[$], cur, held, got;
    logic [7:0] din_q[$];
    longint m_en = 0;
    bit m_tick = 0, tick_now, launch, m_ovr = 0, prev_req = 0;
    int m_debt = 0, m_phase = 0;   // phase: 0 idle, 1 awaiting ack, 2 CE cycle
    logic [7:0] m_din = 8'h0, exp_din;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            m_en = 0; m_tick = 0; m_debt = 0; m_phase = 0; m_ovr = 0; m_din = 8'h0;
            req_q.delete(); din_q.delete();
            chk("rst_addr", mem_addr, 0); chk("rst_we", mem_we, 0); chk("rst_wdata", mem_wdata, 0);
        end else begin
            tick_now = m_tick;
            if (enable) begin
                m_tick = (((m_en + 1) * INC) >> ACC_W) > ((m_en * INC) >> ACC_W);
                m_en++;
            end else m_tick = 0;
            launch = (m_phase == 0) && (m_debt > 0);
            if (tick_now && !launch) begin
                if (m_debt == DMAX) m_ovr = 1; else m_debt++;
            end else if (!tick_now && launch) m_debt--;
            case (m_phase)
                0: if (launch) begin
                       cur.we = cpu_wreq; cur.addr = cpu_wreq ? cpu_ea : cpu_addr; cur.wdata = cpu_dout;
                       req_q.push_back(cur); m_phase = 1;
                   end
                1: if (mem_ack === 1'b1) begin
                       if (!cur.we) m_din = mem_rdata;
                       din_q.push_back(m_din); m_phase = 2;
                   end
                default: m_phase = 0;
            endcase
        end
        chk("ce", cpu_ce, m_phase == 2);
        chk("req", mem_req, m_phase == 1);
        chk("debt", debt, m_debt);
        chk("overrun", overrun, m_ovr);
        got = {mem_we, mem_addr, mem_wdata};
        if (mem_req && !prev_req) begin
            if (req_q.size() == 0) begin bad++; total++; $display("FAIL req_unexpected: got req want none"); end
            else begin held = req_q.pop_front(); chk("req_fields", got, held); end
        end else if (mem_req) chk("req_stable", got, held);
        if (cpu_ce) begin
            if (din_q.size() == 0) begin bad++; total++; $display("FAIL ce_unexpected: got ce want none"); end
            else begin exp_din = din_q.pop_front(); chk("ce_din", cpu_din, exp_din); end
        end else chk("din_hold", cpu_din, m_din);
        prev_req = mem_req;
    end

    task automatic wait_ev(input bit want_ce, input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (want_ce ? cpu_ce : mem_req) return;
        end
        total++; bad++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    task automatic gap_to_ce(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_ce && n < 100);
    endtask

    int n, last, ce_seen;
    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_debt", debt, 0); chk("rst_ce", cpu_ce, 0); chk("rst_din", cpu_din, 0);

        // Rate: ack one cycle after every request, CE every 4 clk
        enable = 1'b1; last = -1; ce_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("rate_debt_le1", debt <= 3'd1, 1);
            if (cpu_ce) begin
                if (ce_seen > 0) chk("rate_spacing", i - last, 4);
                last = i; ce_seen++;
            end
        end
        chk("rate_count_min", ce_seen >= 248, 1);

        // Directed read
        rand_in = 1'b0; fix_addr = 16'h8123; fix_wreq = 1'b0; use_fixed = 1'b1; rdata_fixed = 8'hA5;
        wait_ev(1, "read_prev_ce"); wait_ev(0, "read_req");
        chk("read_addr", mem_addr, 16'h8123); chk("read_we", mem_we, 0);
        wait_ev(1, "read_ce"); chk("read_din", cpu_din, 8'hA5);

        // Directed write, response delayed so hold is observed
        fix_ea = 16'h0200; fix_dout = 8'h3C; fix_wreq = 1'b1; ack_delay = 3;
        wait_ev(1, "wr_prev_ce"); wait_ev(0, "wr_req");
        chk("wr_we", mem_we, 1); chk("wr_addr", mem_addr, 16'h0200); chk("wr_data", mem_wdata, 8'h3C);
        wait_ev(1, "wr_ce"); chk("wr_din_kept", cpu_din, 8'hA5);
        ack_delay = 0; rand_in = 1'b1; use_fixed = 1'b0;

        // Catch-up and overrun
        ack_hold = 1'b1;
        wait_ev(0, "hold_req");
        repeat (40) @(negedge clk);
        chk("sat_debt", debt, DMAX); chk("sat_overrun", overrun, 1);
        ack_hold = 1'b0;
        wait_ev(1, "hold_ce");
        for (int k = 0; k < 7; k++) begin gap_to_ce(n); chk("catchup_gap", n, 3); end

        // enable=0 while waiting for an ack
        ack_delay = 2;
        wait_ev(1, "dis_prev_ce"); wait_ev(0, "dis_req");
        enable = 1'b0;
        wait_ev(1, "dis_ce");
        repeat (60) @(negedge clk);
        chk("dis_drained", debt, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (cpu_ce) n++; end
        chk("dis_no_ce", n, 0);
        enable = 1'b1; ack_delay = 0;
        repeat (100) @(negedge clk);

        // Reset during WAIT, late ack ignored
        ack_hold = 1'b1;
        wait_ev(0, "rw_req");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; ack_hold = 1'b0;
        chk("rw_req0", mem_req, 0); chk("rw_debt0", debt, 0); chk("rw_ce0", cpu_ce, 0);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (cpu_ce) n++; end
        chk("rw_no_ce", n, 0);

        // Random soak: varying latency, enable toggling, stray acks
        spurious = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ack_delay = $urandom_range(0, 6);
            enable = ($urandom_range(0, 4) != 0);
            repeat (50) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_bus_ctrl.md
# cpu_bus_ctrl

Clock-enable and memory-handshake controller between the 6502 core and the system memory port. It replaces the free-running CPU clock with a fractional-rate clock-enable derived from the 100 MHz `clk`, and holds each CPU cycle until memory acknowledges. Missed CPU cycles are tracked so slow memory accesses are caught up later. It sits between the `cpu` instance (CE/ADDR/EA/WREQ/DIN/DOUT) and the SDRAM/BRAM arbiter in the `nes` top level.

## Interface
- `ACC_W`, 16: phase accumulator width.
- `INC`, 1173: accumulator increment per `clk`. Tick rate = INC/2^ACC_W × f_clk (1173 gives ≈1.790 MHz at 100 MHz).
- `DEBT_W`, 3: width of the pending-cycle (debt) counter. DEBT_MAX = 2^DEBT_W − 1.
- `ADDR_W`, 16: memory address width (low bits of the CPU address).
- `DATA_W`, 8: data width.

- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  synchronous reset, active-high.
- `enable`  in  1  1 = accumulator runs; 0 = no new ticks.
- `cpu_addr`  in  16  CPU read address (ADDR).
- `cpu_ea`  in  16  CPU write address (EA).
- `cpu_wreq`  in  1  CPU write request (WREQ).
- `cpu_dout`  in  DATA_W  CPU write data (DOUT).
- `cpu_din`  out  DATA_W  read data to CPU (DIN).
- `cpu_ce`  out  1  one-`clk` CPU clock-enable (CE).
- `mem_req`  out  1  memory request, held until ack.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_ack`.
- `mem_ack`  in  1  one-`clk` acknowledge.
- `debt`  out  DEBT_W  pending CPU cycles (debug).
- `overrun`  out  1  sticky: a tick arrived while debt = DEBT_MAX.

## Operation
- Phase accumulator: `acc <= acc + INC` (mod 2^ACC_W) when `enable`=1. `tick` = carry out of that addition, registered.
- Debt counter: +1 on `tick`; −1 when a CPU cycle is launched (IDLE→WAIT). Both in the same clock: unchanged. A tick when debt = DEBT_MAX is dropped and sets `overrun`. Debt never goes below 0.
- FSM, three states:
  - IDLE: if debt > 0, latch `mem_we`=`cpu_wreq`, `mem_addr`=(`cpu_wreq` ? `cpu_ea` : `cpu_addr`)[ADDR_W-1:0], `mem_wdata`=`cpu_dout`. Assert `mem_req`. Go to WAIT.
  - WAIT: `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` held stable. On `mem_ack`=1:
    - deassert `mem_req`;
    - if read, load `cpu_din` <= `mem_rdata`;
    - go to DONE.
  - DONE: `cpu_ce`=1 for exactly this cycle. Go to IDLE. IDLE never launches while `cpu_ce`=1, so the CPU's next address is always used.
- `cpu_din` holds its last value across writes and idle periods.
- `enable`=0:
  - accumulator frozen, no new ticks;
  - an in-flight access completes normally, including its `cpu_ce`;
  - remaining debt is still drained;
  - debt and accumulator are retained.
- `mem_ack` outside WAIT is ignored.

## Timing
- Reset values: acc=0, debt=0, state IDLE, `cpu_ce`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_din`=0, `overrun`=0.
- Reset mid-access: `mem_req` drops at the reset edge. The outstanding request is abandoned and a late `mem_ack` is ignored. The memory side tolerates abandoned requests.
- Latency:
  - tick is registered: debt increments the clock after the carry.
  - IDLE sees debt > 0 → `mem_req` high next edge.
  - ack sampled at edge N → `cpu_din` valid and `cpu_ce`=1 during cycle N+1.
  - IDLE again at N+2.
- Minimum CPU cycle: 3 `clk` (ack in the first WAIT cycle). Sustained rate = min(tick rate, 1/(access time + 2)).
- Catch-up: while debt > 0, accesses run back-to-back with no idle gap.

## Test plan
- Rate: ACC_W=16, INC=16384, `mem_ack` one cycle after every `mem_req` → `cpu_ce` every 4 clk, debt stays 0/1, `overrun`=0 over 1000 cycles.
- Read: `cpu_addr`=0x8123, `cpu_wreq`=0, ack with `mem_rdata`=0xA5 → `mem_addr`=0x8123, `mem_we`=0, `cpu_din`=0xA5 exactly during the single `cpu_ce` cycle.
- Write: `cpu_ea`=0x0200, `cpu_dout`=0x3C, `cpu_wreq`=1 → `mem_we`=1, `mem_addr`=0x0200, `mem_wdata`=0x3C held stable until ack; `cpu_din` unchanged.
- Catch-up and overrun: INC=16384, DEBT_W=3, ack withheld 40 clk → debt saturates at 7 and `overrun`=1. After ack, 7 further `cpu_ce` pulses follow at 3-clk spacing.
- `enable`=0 during WAIT → access completes with one `cpu_ce`; no further ticks; acc value unchanged until `enable`=1.
- Reset asserted in WAIT → next cycle `mem_req`=0, debt=0, `cpu_ce`=0. A `mem_ack` one cycle after reset produces no `cpu_ce`.
